// File: rtl/prewish_pkg.sv
// rtl/prewish_pkg.sv - shared FSM encoding and playlist constant for the mask arbiter
package prewish_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int PLAYLIST_LEN = 8;

    // Entry i lives in slice [i]; entry 0 is the rightmost byte.
    localparam logic [PLAYLIST_LEN-1:0][7:0] PLAYLIST = {
        8'hE0, 8'hCC, 8'hD5, 8'hD4, 8'hFF, 8'hA8, 8'hA0, 8'h80
    };

endpackage

// File: rtl/prewish_tick_gen.sv
// rtl/prewish_tick_gen.sv - free-running period counter producing a one-cycle wrap tick
module prewish_tick_gen #(
    parameter int AUTO_PERIOD_BITS = 28
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic enable_i,
    output logic tick_o
);

    logic [AUTO_PERIOD_BITS-1:0] cnt_q;

    // Count while enabled; disabling restarts the period from zero.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_q <= '0;
        end else if (!enable_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The tick marks the cycle whose edge wraps the counter from all-ones to zero.
    assign tick_o = enable_i & ~RST_I & (&cnt_q);

endmodule

// File: rtl/prewish_mask_arbiter.sv
// rtl/prewish_mask_arbiter.sv - arbitrates button and timed playlist masks onto one write port
module prewish_mask_arbiter
    import prewish_pkg::*;
#(
    parameter int HOLDOFF_CYCLES   = 8,
    parameter int AUTO_PERIOD_BITS = 28,
    parameter int ALIVE_BITS       = 23
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_btn_stb,
    input  logic [7:0] i_btn_dat,
    input  logic       i_auto_en,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic       o_btn_ack,
    output logic       o_busy,
    output logic       o_alive
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

    state_t                state_q;
    logic [7:0]            hold_cnt_q;
    logic                  btn_pend_q;
    logic [7:0]            btn_data_q;
    logic                  auto_pend_q;
    logic [2:0]            idx_q;
    logic [ALIVE_BITS-1:0] alive_q;
    logic                  stb_q;
    logic [7:0]            dat_q;
    logic                  ack_q;
    logic                  auto_tick;
    logic                  grant_btn_d;
    logic                  grant_auto_d;

    prewish_tick_gen #(
        .AUTO_PERIOD_BITS(AUTO_PERIOD_BITS)
    ) u_tick_gen (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .enable_i(i_auto_en),
        .tick_o  (auto_tick)
    );

    // Button always wins a grant; the playlist only goes when no button mask waits.
    assign grant_btn_d  = (state_q == ST_IDLE) & btn_pend_q;
    assign grant_auto_d = (state_q == ST_IDLE) & ~btn_pend_q & auto_pend_q;

    // Pending flags: a fresh button pulse beats its own grant so it is never lost.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            btn_pend_q  <= 1'b0;
            btn_data_q  <= 8'h00;
            auto_pend_q <= 1'b0;
        end else begin
            if (i_btn_stb) begin
                btn_pend_q <= 1'b1;
                btn_data_q <= i_btn_dat;
            end else if (grant_btn_d) begin
                btn_pend_q <= 1'b0;
            end

            if (!i_auto_en) begin
                auto_pend_q <= 1'b0;
            end else if (grant_auto_d) begin
                auto_pend_q <= 1'b0;
            end else if (auto_tick) begin
                auto_pend_q <= 1'b1;
            end
        end
    end

    // Write sequencer: one strobe cycle followed by a fixed idle holdoff.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 8'h00;
            idx_q      <= 3'd0;
            stb_q      <= 1'b0;
            dat_q      <= 8'h00;
            ack_q      <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_btn_d) begin
                        state_q <= ST_SEND;
                        stb_q   <= 1'b1;
                        ack_q   <= 1'b1;
                        dat_q   <= btn_data_q;
                    end else if (grant_auto_d) begin
                        state_q <= ST_SEND;
                        stb_q   <= 1'b1;
                        dat_q   <= PLAYLIST[idx_q];
                        idx_q   <= idx_q + 3'd1;
                    end
                end
                ST_SEND: begin
                    state_q    <= ST_HOLDOFF;
                    hold_cnt_q <= HOLD_LOAD;
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q == 8'h00) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'h01;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Heartbeat counter; its MSB shows the clock is running.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            alive_q <= '0;
        end else begin
            alive_q <= alive_q + 1'b1;
        end
    end

    assign STB_O     = stb_q;
    assign DAT_O     = dat_q;
    assign o_btn_ack = ack_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_alive   = alive_q[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish_mask_arbiter.sv
// tb/tb_prewish_mask_arbiter.sv - directed self-checking bench for the mask arbiter
module tb_prewish_mask_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_stb;
    logic [7:0] btn_dat;
    logic       auto_en;
    logic       stb;
    logic [7:0] dat;
    logic       ack;
    logic       busy;
    logic       alive;

    int total = 0;
    int bad   = 0;
    int n;
    int strobes;

    logic [7:0] pl [8] = '{8'h80, 8'hA0, 8'hA8, 8'hFF, 8'hD4, 8'hD5, 8'hCC, 8'hE0};

    prewish_mask_arbiter #(
        .HOLDOFF_CYCLES  (4),
        .AUTO_PERIOD_BITS(4),
        .ALIVE_BITS      (4)
    ) dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .i_btn_stb(btn_stb),
        .i_btn_dat(btn_dat),
        .i_auto_en(auto_en),
        .STB_O    (stb),
        .DAT_O    (dat),
        .o_btn_ack(ack),
        .o_busy   (busy),
        .o_alive  (alive)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_stb(input int max_cyc, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (stb !== 1'b1 && cycles < max_cyc);
        total++;
        assert (stb === 1'b1) else begin
            bad++;
            $error("FAIL stb_timeout observed=%0b expected=1 after %0d cycles", stb, cycles);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_stb = 1'b1;
        btn_dat = 8'hEE;
        auto_en = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_stb", 8'(stb), 8'h0);
        chk("rst_dat", dat, 8'h00);
        chk("rst_ack", 8'(ack), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_alive", 8'(alive), 8'h0);

        rst     = 1'b0;
        btn_stb = 1'b0;
        repeat (7) step();
        chk("ignored_in_rst_stb", 8'(stb), 8'h0);
        chk("ignored_in_rst_busy", 8'(busy), 8'h0);
        chk("alive_cnt7", 8'(alive), 8'h0);
        step();
        chk("alive_cnt8", 8'(alive), 8'h1);

        btn_stb = 1'b1;
        btn_dat = 8'h5A;
        step();
        btn_stb = 1'b0;
        chk("btn_lat1_stb", 8'(stb), 8'h0);
        step();
        chk("btn_stb", 8'(stb), 8'h1);
        chk("btn_dat", dat, 8'h5A);
        chk("btn_ack", 8'(ack), 8'h1);
        chk("btn_busy_send", 8'(busy), 8'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_stb", 8'(stb), 8'h0);
            chk("hold_ack", 8'(ack), 8'h0);
            chk("hold_busy", 8'(busy), 8'h1);
            chk("hold_dat", dat, 8'h5A);
        end
        step();
        chk("idle_busy", 8'(busy), 8'h0);

        auto_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_stb(40, n);
            chk("auto_spacing", 8'(n), (k == 0) ? 8'd17 : 8'd16);
            chk("auto_dat", dat, pl[k % 8]);
            chk("auto_ack", 8'(ack), 8'h0);
        end
        auto_en = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (stb === 1'b1) strobes++;
        end
        chk("auto_off_quiet", 8'(strobes), 8'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_dat", dat, 8'h00);
        auto_en = 1'b1;
        repeat (15) step();
        btn_stb = 1'b1;
        btn_dat = 8'h3C;
        step();
        btn_stb = 1'b0;
        chk("tie_lat1_stb", 8'(stb), 8'h0);
        step();
        chk("tie_btn_stb", 8'(stb), 8'h1);
        chk("tie_btn_dat", dat, 8'h3C);
        chk("tie_btn_ack", 8'(ack), 8'h1);
        wait_stb(20, n);
        chk("tie_gap", 8'(n), 8'd6);
        chk("tie_auto_dat", dat, 8'h80);
        chk("tie_auto_ack", 8'(ack), 8'h0);
        wait_stb(20, n);
        chk("tie_next_gap", 8'(n), 8'd10);
        chk("tie_next_dat", dat, 8'hA0);
        auto_en = 1'b0;

        repeat (6) step();
        btn_stb = 1'b1;
        btn_dat = 8'h77;
        step();
        btn_stb = 1'b0;
        step();
        chk("ow_first_stb", 8'(stb), 8'h1);
        chk("ow_first_dat", dat, 8'h77);
        step();
        btn_stb = 1'b1;
        btn_dat = 8'h11;
        step();
        btn_stb = 1'b0;
        step();
        btn_stb = 1'b1;
        btn_dat = 8'h22;
        step();
        btn_stb = 1'b0;
        wait_stb(20, n);
        chk("ow_gap", 8'(n), 8'd2);
        chk("ow_dat", dat, 8'h22);
        chk("ow_ack", 8'(ack), 8'h1);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (stb === 1'b1) strobes++;
        end
        chk("ow_single", 8'(strobes), 8'd0);

        auto_en = 1'b1;
        repeat (13) step();
        btn_stb = 1'b1;
        btn_dat = 8'h99;
        step();
        btn_stb = 1'b0;
        step();
        chk("rh_btn_stb", 8'(stb), 8'h1);
        chk("rh_btn_dat", dat, 8'h99);
        step();
        chk("rh_hold_busy", 8'(busy), 8'h1);
        rst = 1'b1;
        step();
        step();
        chk("rh_rst_dat", dat, 8'h00);
        chk("rh_rst_stb", 8'(stb), 8'h0);
        chk("rh_rst_busy", 8'(busy), 8'h0);
        rst = 1'b0;
        wait_stb(40, n);
        chk("rh_gap", 8'(n), 8'd17);
        chk("rh_auto_dat", dat, 8'h80);
        chk("rh_auto_ack", 8'(ack), 8'h0);
        auto_en = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
